// File: rtl/ps2_fifo_pkg.sv
// Shared constants and helpers for the PS2 / 8051 receive FIFO.
package ps2_fifo_pkg;

  localparam int unsigned PS2_FIFO_DEPTH_DEFAULT = 8;
  localparam int unsigned PS2_FIFO_WIDTH_DEFAULT = 8;

  // Occupancy counter width: one extra bit so the count can reach DEPTH.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage : ps2_fifo_pkg

// File: rtl/ps2_fifo_ext_if.sv
// Writer/reader bus of the receive FIFO; master drives requests, slave is the FIFO.
// PS2_FIFO_HIGH_WATER_EN adds the fifo_high_water status signal.
interface ps2_fifo_ext_if #(
  parameter int unsigned WIDTH = ps2_fifo_pkg::PS2_FIFO_WIDTH_DEFAULT,
  parameter int unsigned CNT_W = ps2_fifo_pkg::cnt_width(ps2_fifo_pkg::PS2_FIFO_DEPTH_DEFAULT)
);

  logic             fifo_flush;
  logic             fifo_write;
  logic [WIDTH-1:0] fifo_data_in;
  logic             fifo_read;
  logic             err_clear;
  logic [WIDTH-1:0] fifo_top_data_out;
  logic             fifo_not_empty;
  logic             fifo_full;
  logic             fifo_almost_full;
  logic             fifo_almost_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             err_overflow;
  logic             err_underflow;
`ifdef PS2_FIFO_HIGH_WATER_EN
  logic [CNT_W-1:0] fifo_high_water;
`endif

  modport master (
    output fifo_flush,
    output fifo_write,
    output fifo_data_in,
    output fifo_read,
    output err_clear,
    input  fifo_top_data_out,
    input  fifo_not_empty,
    input  fifo_full,
    input  fifo_almost_full,
    input  fifo_almost_empty,
    input  fifo_count,
    input  err_overflow,
`ifdef PS2_FIFO_HIGH_WATER_EN
    input  fifo_high_water,
`endif
    input  err_underflow
  );

  modport slave (
    input  fifo_flush,
    input  fifo_write,
    input  fifo_data_in,
    input  fifo_read,
    input  err_clear,
    output fifo_top_data_out,
    output fifo_not_empty,
    output fifo_full,
    output fifo_almost_full,
    output fifo_almost_empty,
    output fifo_count,
    output err_overflow,
`ifdef PS2_FIFO_HIGH_WATER_EN
    output fifo_high_water,
`endif
    output err_underflow
  );

endinterface : ps2_fifo_ext_if

// File: rtl/ps2_fifo_mem.sv
// DEPTH x WIDTH register-file storage: synchronous write, asynchronous read.
module ps2_fifo_mem #(
  parameter int unsigned DEPTH = ps2_fifo_pkg::PS2_FIFO_DEPTH_DEFAULT,
  parameter int unsigned WIDTH = ps2_fifo_pkg::PS2_FIFO_WIDTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  // Storage is intentionally unreset; contents are only observed once written.
  (* ramstyle = "logic" *) logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule : ps2_fifo_mem

// File: rtl/ps2_fifo_ext.sv
// Show-ahead receive FIFO with exact count, threshold flags, sticky errors and flush.
// Optional PS2_FIFO_HIGH_WATER_EN adds a peak-occupancy tracker (fifo_high_water).
module ps2_fifo_ext
  import ps2_fifo_pkg::*;
#(
  parameter int unsigned DEPTH     = PS2_FIFO_DEPTH_DEFAULT,
  parameter int unsigned WIDTH     = PS2_FIFO_WIDTH_DEFAULT,
  parameter int unsigned AF_THRESH = DEPTH - 2,
  parameter int unsigned AE_THRESH = 1
) (
  input  logic          clk,
  input  logic          reset,
  ps2_fifo_ext_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = cnt_width(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("ps2_fifo_ext: DEPTH must be a power of two >= 2");
  end
  if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_bad_af
    $error("ps2_fifo_ext: AF_THRESH must be in 1..DEPTH");
  end
  if (AE_THRESH > DEPTH - 1) begin : g_bad_ae
    $error("ps2_fifo_ext: AE_THRESH must be in 0..DEPTH-1");
  end

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             err_ovf_q, err_ovf_d;
  logic             err_udf_q, err_udf_d;
`ifdef PS2_FIFO_HIGH_WATER_EN
  logic [CNT_W-1:0] hw_q, hw_d;
`endif

  logic rd_ok_c;
  logic wr_ok_c;
  logic mem_we_c;
  logic empty_c;
  logic full_c;

  assign empty_c  = (count_q == '0);
  assign full_c   = (count_q == CNT_W'(DEPTH));
  assign rd_ok_c  = bus.fifo_read & ~empty_c;
  // A write into a full FIFO is only legal when a pop frees the slot the same cycle.
  assign wr_ok_c  = bus.fifo_write & (~full_c | rd_ok_c);
  assign mem_we_c = wr_ok_c & ~bus.fifo_flush;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    err_ovf_d = bus.err_clear ? 1'b0 : err_ovf_q;
    err_udf_d = bus.err_clear ? 1'b0 : err_udf_q;

    if (bus.fifo_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_ok_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (rd_ok_c) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(wr_ok_c) - CNT_W'(rd_ok_c);
      // Set beats a coincident err_clear.
      if (bus.fifo_write & ~wr_ok_c) err_ovf_d = 1'b1;
      if (bus.fifo_read & empty_c)   err_udf_d = 1'b1;
    end
  end

`ifdef PS2_FIFO_HIGH_WATER_EN
  always_comb begin
    hw_d = hw_q;
    if (bus.err_clear) begin
      hw_d = count_d;
    end else if (count_d > hw_q) begin
      hw_d = count_d;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
`ifdef PS2_FIFO_HIGH_WATER_EN
      hw_q      <= '0;
`endif
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      err_ovf_q <= err_ovf_d;
      err_udf_q <= err_udf_d;
`ifdef PS2_FIFO_HIGH_WATER_EN
      hw_q      <= hw_d;
`endif
    end
  end

  ps2_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we_c),
    .waddr (wr_ptr_q),
    .wdata (bus.fifo_data_in),
    .raddr (rd_ptr_q),
    .rdata (bus.fifo_top_data_out)
  );

  // Status flags are pure decodes of the registered count.
  assign bus.fifo_count        = count_q;
  assign bus.fifo_not_empty    = ~empty_c;
  assign bus.fifo_full         = full_c;
  assign bus.fifo_almost_full  = (count_q >= CNT_W'(AF_THRESH));
  assign bus.fifo_almost_empty = (count_q <= CNT_W'(AE_THRESH));
  assign bus.err_overflow      = err_ovf_q;
  assign bus.err_underflow     = err_udf_q;
`ifdef PS2_FIFO_HIGH_WATER_EN
  assign bus.fifo_high_water   = hw_q;
`endif

endmodule : ps2_fifo_ext

// File: tb/tb_ps2_fifo_ext.sv
// Bench for ps2_fifo_ext: directed scenarios plus random traffic against a queue model.
module tb_ps2_fifo_ext;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned AF    = DEPTH - 2;
  localparam int unsigned AE    = 1;
  localparam int unsigned CNT_W = ps2_fifo_pkg::cnt_width(DEPTH);

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  ps2_fifo_ext_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  ps2_fifo_ext #(
    .DEPTH     (DEPTH),
    .WIDTH     (WIDTH),
    .AF_THRESH (AF),
    .AE_THRESH (AE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  // Reference model state
  logic [WIDTH-1:0] mq[$];
  logic             m_ovf, m_udf;
  int unsigned      m_hw;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    m_hw  = 0;
  endtask

  task automatic model_step(input logic fl, input logic wr, input logic [WIDTH-1:0] d,
                            input logic rd, input logic clr);
    int unsigned n;
    logic        rok, wok;
    n   = mq.size();
    rok = rd && (n != 0);
    wok = wr && ((n < DEPTH) || rok);
    if (fl) begin
      mq.delete();
    end else begin
      if (rok) void'(mq.pop_front());
      if (wok) mq.push_back(d);
    end
    m_ovf = (wr && !wok && !fl) ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_udf = (rd && (n == 0) && !fl) ? 1'b1 : (clr ? 1'b0 : m_udf);
    if (clr) m_hw = mq.size();
    else if (mq.size() > m_hw) m_hw = mq.size();
  endtask

  task automatic check_all(input string tag);
    int unsigned n;
    n = mq.size();
    check({tag, "_count"}, 32'(bus.fifo_count), 32'(n));
    check({tag, "_not_empty"}, 32'(bus.fifo_not_empty), 32'(n != 0));
    check({tag, "_full"}, 32'(bus.fifo_full), 32'(n == DEPTH));
    check({tag, "_afull"}, 32'(bus.fifo_almost_full), 32'(n >= AF));
    check({tag, "_aempty"}, 32'(bus.fifo_almost_empty), 32'(n <= AE));
    check({tag, "_ovf"}, 32'(bus.err_overflow), 32'(m_ovf));
    check({tag, "_udf"}, 32'(bus.err_underflow), 32'(m_udf));
    if (n != 0) check({tag, "_top"}, 32'(bus.fifo_top_data_out), 32'(mq[0]));
`ifdef PS2_FIFO_HIGH_WATER_EN
    check({tag, "_hw"}, 32'(bus.fifo_high_water), m_hw);
`endif
  endtask

  // Drive one cycle of inputs, clock it, then compare against the model.
  task automatic cyc(input string tag, input logic fl, input logic wr, input logic [WIDTH-1:0] d,
                     input logic rd, input logic clr);
    bus.fifo_flush   = fl;
    bus.fifo_write   = wr;
    bus.fifo_data_in = d;
    bus.fifo_read    = rd;
    bus.err_clear    = clr;
    @(posedge clk);
    #1;
    model_step(fl, wr, d, rd, clr);
    bus.fifo_flush = 1'b0;
    bus.fifo_write = 1'b0;
    bus.fifo_read  = 1'b0;
    bus.err_clear  = 1'b0;
    check_all(tag);
  endtask

  initial begin
    int unsigned wp, rp;
    bus.fifo_flush   = 1'b0;
    bus.fifo_write   = 1'b0;
    bus.fifo_data_in = '0;
    bus.fifo_read    = 1'b0;
    bus.err_clear    = 1'b0;
    reset = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_all("reset");
    check("reset_aempty_const", 32'(bus.fifo_almost_empty), 32'd1);

    // 1: fill then drain in order
    for (int i = 0; i < 8; i++) cyc("t1_fill", 1'b0, 1'b1, 8'(8'h11 + i), 1'b0, 1'b0);
    check("t1_count8", 32'(bus.fifo_count), 32'd8);
    check("t1_full", 32'(bus.fifo_full), 32'd1);
    for (int i = 0; i < 8; i++) begin
      check("t1_pop_data", 32'(bus.fifo_top_data_out), 32'(8'h11 + i));
      cyc("t1_drain", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    end
    check("t1_count0", 32'(bus.fifo_count), 32'd0);

    // 2: overflow while full, then clear
    for (int i = 0; i < 8; i++) cyc("t2_fill", 1'b0, 1'b1, 8'(8'h11 + i), 1'b0, 1'b0);
    cyc("t2_ovf", 1'b0, 1'b1, 8'hAA, 1'b0, 1'b0);
    check("t2_ovf_set", 32'(bus.err_overflow), 32'd1);
    cyc("t2_clr", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    check("t2_ovf_clr", 32'(bus.err_overflow), 32'd0);

    // 3: write+read while full keeps count at DEPTH
    check("t3_head", 32'(bus.fifo_top_data_out), 32'h11);
    cyc("t3_wr_rd", 1'b0, 1'b1, 8'h55, 1'b1, 1'b0);
    check("t3_count8", 32'(bus.fifo_count), 32'd8);
    for (int i = 0; i < 7; i++) cyc("t3_pop", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check("t3_last55", 32'(bus.fifo_top_data_out), 32'h55);
    cyc("t3_pop_last", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

    // 4: read+write on empty: underflow, write still lands
    cyc("t4_udf", 1'b0, 1'b1, 8'h3C, 1'b1, 1'b0);
    check("t4_udf_set", 32'(bus.err_underflow), 32'd1);
    check("t4_top3c", 32'(bus.fifo_top_data_out), 32'h3C);
    cyc("t4_pop", 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

    // 5: wrap pointers, then flush with a concurrent write
    for (int i = 0; i < 20; i++) begin
      cyc("t5_wr", 1'b0, 1'b1, 8'($urandom), 1'b0, 1'b0);
      cyc("t5_rd", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    end
    for (int i = 0; i < 5; i++) cyc("t5_fill", 1'b0, 1'b1, 8'($urandom), 1'b0, 1'b0);
    cyc("t5_flush", 1'b1, 1'b1, 8'h77, 1'b0, 1'b0);
    check("t5_flush_ovf", 32'(bus.err_overflow), 32'd0);

    // 6: peak of 6, settle at 4, then asynchronous reset between edges
    for (int i = 0; i < 6; i++) cyc("t6_fill", 1'b0, 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    cyc("t6_rd", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    cyc("t6_rd", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
`ifdef PS2_FIFO_HIGH_WATER_EN
    check("t6_hw6", 32'(bus.fifo_high_water), 32'd6);
`endif
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("t6_async");
    check("t6_async_count", 32'(bus.fifo_count), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Random traffic, alternating fill-biased and drain-biased phases
    for (int i = 0; i < 3000; i++) begin
      wp = ((i / 200) % 2 == 0) ? 75 : 35;
      rp = ((i / 200) % 2 == 0) ? 35 : 75;
      cyc("rand",
          ($urandom_range(0, 63) == 0),
          ($urandom_range(0, 99) < wp),
          8'($urandom),
          ($urandom_range(0, 99) < rp),
          ($urandom_range(0, 31) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_ps2_fifo_ext
